// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, memory-access FSM states and the
// request legality helpers used by the memory-access stage.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mau_state_t;

  // Stores only have signed encodings; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lane);
    logic ok;
    ok = 1'b1;
    case (f3)
      F3_H, F3_HU: ok = ~lane[0];
      F3_W:        ok = (lane == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: selects the addressed byte/halfword from a raw
// 32-bit memory word and sign- or zero-extends it per the load funct3.
module load_align
  import rv32i_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth-1:0] rdata,
  input  logic [1:0]           lane,
  input  logic [2:0]           funct3,
  output logic [DataWidth-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction and extension of the selected field.
  always_comb begin
    byte_sel = rdata[8*lane +: 8];
    half_sel = rdata[16*lane[1] +: 16];
    ext_data = rdata;
    case (funct3)
      F3_B:    ext_data = {{(DataWidth-8){byte_sel[7]}}, byte_sel};
      F3_BU:   ext_data = {{(DataWidth-8){1'b0}}, byte_sel};
      F3_H:    ext_data = {{(DataWidth-16){half_sel[15]}}, half_sel};
      F3_HU:   ext_data = {{(DataWidth-16){1'b0}}, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I memory-access stage: accepts one load/store at a time, runs the
// req/gnt/rvalid handshake with data memory, formats store lanes/strobes and
// returns aligned, extended load data to write-back.
module mem_access_unit
  import rv32i_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 load_valid,
  output logic [DataWidth-1:0] data_mem_out,
  output logic                 store_done,
  output logic                 access_err
);

  mau_state_t state, state_nxt;

  logic                 req_we_p0;
  logic [2:0]           req_f3_p0;
  logic [AddrWidth-1:0] req_addr_p0;
  logic [DataWidth-1:0] req_wdata_p0;

  logic                 accept;
  logic                 req_ok;
  logic [DataWidth-1:0] load_ext;

  assign accept = (state == IDLE) && req_valid;
  assign req_ok = f3_legal(req_we, req_funct3) && addr_aligned(req_funct3, req_addr[1:0]);

  load_align #(
    .DataWidth(DataWidth)
  ) u_load_align (
    .rdata   (mem_rdata),
    .lane    (req_addr_p0[1:0]),
    .funct3  (req_f3_p0),
    .ext_data(load_ext)
  );

  // State register; async reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; stray gnt/rvalid outside their states fall to default hold.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && req_ok) state_nxt = REQ;
      REQ:     if (mem_gnt) state_nxt = req_we_p0 ? IDLE : WAIT_R;
      WAIT_R:  if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs: driven from the request latches only while requesting.
  always_comb begin
    req_ready = (state == IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    if (state == REQ) begin
      mem_req  = 1'b1;
      mem_we   = req_we_p0;
      mem_addr = {req_addr_p0[AddrWidth-1:2], 2'b00};
      if (req_we_p0) begin
        case (req_f3_p0)
          F3_B: begin
            mem_wdata = {4{req_wdata_p0[7:0]}};
            mem_wstrb = 4'b0001 << req_addr_p0[1:0];
          end
          F3_H: begin
            mem_wdata = {2{req_wdata_p0[15:0]}};
            mem_wstrb = 4'b0011 << req_addr_p0[1:0];
          end
          default: begin
            mem_wdata = req_wdata_p0;
            mem_wstrb = 4'b1111;
          end
        endcase
      end
    end
  end

  // Request latch: captured on every accept, held through the transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_p0    <= req_we;
      req_f3_p0    <= req_funct3;
      req_addr_p0  <= req_addr;
      req_wdata_p0 <= req_wdata;
    end
  end

  // Completion pulses and the write-back load register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid   <= 1'b0;
      store_done   <= 1'b0;
      access_err   <= 1'b0;
      data_mem_out <= '0;
    end else begin
      load_valid <= (state == WAIT_R) && mem_rvalid;
      store_done <= (state == REQ) && mem_gnt && req_we_p0;
      access_err <= accept && !req_ok;
      if ((state == WAIT_R) && mem_rvalid) data_mem_out <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, error responses,
// async reset mid-transaction and back-to-back stores.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        load_valid;
  logic [31:0] data_mem_out;
  logic        store_done;
  logic        access_err;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.DataWidth(32), .AddrWidth(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .load_valid  (load_valid),
    .data_mem_out(data_mem_out),
    .store_done  (store_done),
    .access_err  (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every step ends at a falling edge: outputs are settled, inputs set here
  // are sampled by the next rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic quiet();
    req_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state
    step();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_dout", data_mem_out, 32'd0);
    chk("rst_pulses", {29'd0, load_valid, store_done, access_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // LB addr 0x1003, negative byte in lane 3
    present(1'b0, 3'b000, 32'h0000_1003, 32'd0);
    step();                                            // T+1
    req_valid = 1'b0;
    chk("lb_memreq", {31'd0, mem_req}, 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_1000);
    chk("lb_we", {31'd0, mem_we}, 32'd0);
    mem_gnt = 1'b1;
    step();                                            // T+2
    mem_gnt = 1'b0;
    chk("lb_req_drop", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_0000;
    step();                                            // T+3
    mem_rvalid = 1'b0;
    chk("lb_valid", {31'd0, load_valid}, 32'd1);
    chk("lb_data", data_mem_out, 32'hFFFF_FF80);
    chk("lb_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("lb_valid_pulse", {31'd0, load_valid}, 32'd0);
    chk("lb_data_hold", data_mem_out, 32'hFFFF_FF80);

    // LHU addr 0x1002, upper halfword zero extended
    present(1'b0, 3'b101, 32'h0000_1002, 32'd0);
    step();
    req_valid = 1'b0;
    chk("lhu_addr", mem_addr, 32'h0000_1000);
    chk("lhu_wstrb", {28'd0, mem_wstrb}, 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001_1234;
    step();
    mem_rvalid = 1'b0;
    chk("lhu_valid", {31'd0, load_valid}, 32'd1);
    chk("lhu_data", data_mem_out, 32'h0000_8001);
    step();

    // SH addr 0x2002 with grant delayed three cycles
    present(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sh_memreq", {31'd0, mem_req}, 32'd1);
      chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("sh_wstrb", {28'd0, mem_wstrb}, 32'h0000_000C);
      chk("sh_addr", mem_addr, 32'h0000_2000);
      chk("sh_done_early", {31'd0, store_done}, 32'd0);
      if (i == 3) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    chk("sh_done", {31'd0, store_done}, 32'd1);
    chk("sh_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    chk("sh_done_pulse", {31'd0, store_done}, 32'd0);

    // SB addr 0x5001: byte replicated, strobe on lane 1
    present(1'b1, 3'b000, 32'h0000_5001, 32'h1234_5678);
    step();
    req_valid = 1'b0;
    chk("sb_wdata", mem_wdata, 32'h7878_7878);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h0000_0002);
    chk("sb_we", {31'd0, mem_we}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sb_done", {31'd0, store_done}, 32'd1);
    step();

    // Misaligned LW, illegal load funct3, illegal store funct3
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       present(1'b0, 3'b010, 32'h0000_1001, 32'd0);
        1:       present(1'b0, 3'b011, 32'h0000_1000, 32'd0);
        default: present(1'b1, 3'b100, 32'h0000_1000, 32'd0);
      endcase
      step();
      req_valid = 1'b0;
      chk("err_pulse", {31'd0, access_err}, 32'd1);
      chk("err_nomemreq", {31'd0, mem_req}, 32'd0);
      chk("err_ready", {31'd0, req_ready}, 32'd1);
      step();
      chk("err_pulse_end", {31'd0, access_err}, 32'd0);
      chk("err_nomemreq2", {31'd0, mem_req}, 32'd0);
    end

    // Async reset while waiting for read data; late rvalid must be ignored
    present(1'b0, 3'b010, 32'h0000_3000, 32'd0);
    step();
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    step();                                            // now in WAIT_R
    mem_gnt = 1'b0;
    chk("wr_ready_busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("wr_rst_dout", data_mem_out, 32'd0);
    chk("wr_rst_memreq", {31'd0, mem_req}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    chk("wr_late_valid", {31'd0, load_valid}, 32'd0);
    chk("wr_late_dout", data_mem_out, 32'd0);
    chk("wr_late_ready", {31'd0, req_ready}, 32'd1);

    // Async reset while requesting: mem_req drops without waiting for a clock
    present(1'b1, 3'b010, 32'h0000_3004, 32'h5555_AAAA);
    step();
    req_valid = 1'b0;
    chk("rq_memreq", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rq_rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rq_rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    step();
    rst_n = 1'b1;
    mem_gnt = 1'b1;                                    // stray grant in IDLE
    step();
    mem_gnt = 1'b0;
    chk("rq_stray_done", {31'd0, store_done}, 32'd0);
    step();

    // Back-to-back SW with grant in the first REQ cycle
    present(1'b1, 3'b010, 32'h0000_4000, 32'h1122_3344);
    step();                                            // T+1
    req_valid = 1'b0;
    chk("b2b_w1", mem_wdata, 32'h1122_3344);
    chk("b2b_s1", {28'd0, mem_wstrb}, 32'h0000_000F);
    mem_gnt = 1'b1;
    step();                                            // T+2
    mem_gnt = 1'b0;
    chk("b2b_done1", {31'd0, store_done}, 32'd1);
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    present(1'b1, 3'b010, 32'h0000_4004, 32'hAABB_CCDD);
    step();                                            // T+3
    req_valid = 1'b0;
    chk("b2b_gap", {31'd0, store_done}, 32'd0);
    chk("b2b_a2", mem_addr, 32'h0000_4004);
    chk("b2b_w2", mem_wdata, 32'hAABB_CCDD);
    mem_gnt = 1'b1;
    step();                                            // T+4
    quiet();
    chk("b2b_done2", {31'd0, store_done}, 32'd1);
    step();
    chk("b2b_idle", {31'd0, req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
